// File: rtl/clint_pkg.sv
// Shared types and register offsets for the core-local interruptor.
package clint_pkg;

    typedef enum logic { ST_IDLE = 1'b0, ST_RESP = 1'b1 } clint_state_e;

    typedef struct packed {
        logic [63:0]  mtime;
        logic [63:0]  mtimecmp;
        logic         msip;
        clint_state_e state;
    } clint_reg_type;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP    = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME       = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        merge_bytes = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) merge_bytes[i*8 +: 8] = wdata[i*8 +: 8];
    endfunction

endpackage

// File: rtl/clint_responder.sv
// Core-local interruptor behind the core memory port: mtime/mtimecmp/msip with
// a two-state request/response handshake and registered interrupt outputs.
module clint_responder
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        timer_irpt,
    output logic        soft_irpt
);

    clint_reg_type r, rin;
    logic [31:0]   pcnt, pcnt_n;
    logic [31:0]   rdata_n, rval;
    logic          timer_n, soft_n;
    logic          tick, accept, hit, wr;
    logic [15:0]   off;
    logic          unused_addr;

    assign unused_addr = &{1'b0, memory_addr[1:0]};
    assign off         = {memory_addr[15:2], 2'b00};

    always_comb begin
        rin     = r;
        rdata_n = memory_rdata;
        rval    = '0;

        tick   = (pcnt == 32'(PRESCALE - 1));
        pcnt_n = tick ? '0 : pcnt + 32'd1;
        if (tick) rin.mtime = r.mtime + 64'd1;

        accept = (r.state == ST_IDLE) && memory_valid;
        // Fetches and out-of-window addresses behave as an empty hole.
        hit    = (memory_addr[31:16] == BASE_ADDR[31:16]) && !memory_instr;
        wr     = accept && hit && (memory_wstrb != 4'b0000);

        if (hit) begin
            case (off)
                CLINT_MSIP:        rval = {31'd0, r.msip};
                CLINT_MTIMECMP:    rval = r.mtimecmp[31:0];
                CLINT_MTIMECMP_HI: rval = r.mtimecmp[63:32];
                CLINT_MTIME:       rval = r.mtime[31:0];
                CLINT_MTIME_HI:    rval = r.mtime[63:32];
                default:           rval = '0;
            endcase
        end

        case (r.state)
            ST_IDLE: if (memory_valid) begin
                rdata_n   = rval;
                rin.state = ST_RESP;
            end
            ST_RESP: rin.state = ST_IDLE;
            default: rin.state = ST_IDLE;
        endcase

        // An mtime write replaces the whole 64-bit next value, dropping any tick.
        if (wr) begin
            case (off)
                CLINT_MSIP: if (memory_wstrb[0]) rin.msip = memory_wdata[0];
                CLINT_MTIMECMP:
                    rin.mtimecmp[31:0]  = merge_bytes(r.mtimecmp[31:0], memory_wdata, memory_wstrb);
                CLINT_MTIMECMP_HI:
                    rin.mtimecmp[63:32] = merge_bytes(r.mtimecmp[63:32], memory_wdata, memory_wstrb);
                CLINT_MTIME:
                    rin.mtime = {r.mtime[63:32], merge_bytes(r.mtime[31:0], memory_wdata, memory_wstrb)};
                CLINT_MTIME_HI:
                    rin.mtime = {merge_bytes(r.mtime[63:32], memory_wdata, memory_wstrb), r.mtime[31:0]};
                default: ;
            endcase
        end

        timer_n = (r.mtime >= r.mtimecmp);
        soft_n  = r.msip;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r.mtime      <= '0;
            r.mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            r.msip       <= 1'b0;
            r.state      <= ST_IDLE;
            pcnt         <= '0;
            memory_rdata <= '0;
            timer_irpt   <= 1'b0;
            soft_irpt    <= 1'b0;
        end else begin
            r            <= rin;
            pcnt         <= pcnt_n;
            memory_rdata <= rdata_n;
            timer_irpt   <= timer_n;
            soft_irpt    <= soft_n;
        end
    end

    assign memory_ready = (r.state == ST_RESP);

endmodule
